// File: rtl/btn_conditioner.sv
// Debounces NBTN raw buttons (2-flop sync + per-button counter; level moves DEBOUNCE_CYCLES+2 edges after the pin settles)
// and latches rising edges as pending events drained lowest-index-first via press_valid/press_ack, one per acked cycle.
module btn_conditioner #(
    parameter int NBTN            = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_level,
    output logic            press_valid,
    output logic [2:0]      press_code,
    output logic            press_ovf,
    input  logic            press_ack,
    output logic [NBTN-1:0] pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0] w_in;
    logic [NBTN-1:0] r_s1;
    logic [NBTN-1:0] r_s2;
    logic [NBTN-1:0] r_level;
    logic [NBTN-1:0] r_pending;
    logic [NBTN-1:0] r_ovf;
    logic [NBTN-1:0] w_rise;
    logic [NBTN-1:0] w_take;
    logic            w_valid;
    logic [2:0]      w_code;
    logic            w_ovf_sel;

    // Normalise polarity ahead of the synchronizer so everything downstream sees 1 = pressed.
    assign w_in = BTN_ACTIVE ? btn_in : ~btn_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [CNT_W-1:0] r_cnt;

            assign w_rise[gi] = r_s2[gi] & ~r_level[gi] & (r_cnt == CNT_LAST);
            assign w_take[gi] = press_ack & w_valid & (w_code == 3'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt       <= '0;
                    r_level[gi] <= 1'b0;
                end else if (r_s2[gi] == r_level[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt       <= '0;
                    r_level[gi] <= r_s2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // A rise coinciding with the take replaces the consumed event, so nothing was lost.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pending[gi] <= 1'b0;
                    r_ovf[gi]     <= 1'b0;
                end else if (w_rise[gi]) begin
                    r_pending[gi] <= 1'b1;
                    r_ovf[gi]     <= (r_pending[gi] & ~w_take[gi]) | (r_ovf[gi] & ~w_take[gi]);
                end else if (w_take[gi]) begin
                    r_pending[gi] <= 1'b0;
                    r_ovf[gi]     <= 1'b0;
                end
            end
        end
    endgenerate

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        w_code    = 3'd0;
        w_ovf_sel = 1'b0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_code    = 3'(i);
                w_ovf_sel = r_ovf[i];
            end
        end
    end

    assign w_valid     = |r_pending;
    assign btn_level   = r_level;
    assign pending     = r_pending;
    assign press_valid = w_valid;
    assign press_code  = w_code;
    assign press_ovf   = w_ovf_sel & w_valid;

endmodule
